ctrl_pipe_decoder: RTL and testbench
====================================

Name: ctrl_pipe_decoder

Overview:
Parametrised successor to the single-cycle control decoder. It decodes the full instruction set (R-type, addi, sw, lw, j, bne, jal, jr, blt, setx, bex) into a control word plus a resolved ALU op. It carries that word down a DEPTH-stage control pipeline with valid bits, load-use stall bubbles, branch flush and illegal-opcode detection. It sits between instruction fetch and the datapath stage registers of the pipelined processor.

Parameters:
DEPTH, 4, number of control stages (stage 0 = ID/EX register); legal range 2..8
CNT_W, 8, width of the saturating illegal-opcode counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  instr holds a real fetched instruction
instr  input  32  instruction; opcode = instr[31:27], R-type ALU op = instr[6:2]
stall  input  1  load-use stall: hold stage 0, inject a bubble into stage 1
flush  input  1  branch/jump taken: kill stages 0 and 1
stage_word  output  DEPTH*17  per stage {alu_op[4:0], ctrl[11:0]}; stage k at bits [17k+16:17k]
stage_valid  output  DEPTH  per-stage valid bit
id_illegal  output  1  registered; stage 0 holds an illegal opcode
illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all stage_word = 0, stage_valid = 0, id_illegal = 0, illegal_cnt = 0. Reset has priority over stall and flush. Asserting reset mid-stream discards every stage on the next edge.
- ctrl bit map (bits 0..7 keep the legacy positions): 0 Rwd, 1 Rdst, 2 Rwe, 3 DMwe, 4 ALUopSel, 5 ALUinB, 6 JP, 7 BR, 8 JAL, 9 JR, 10 SETX, 11 BEX.
- Decode table (opcode: ctrl / alu_op):
  - 00000 R: Rwe|Rdst|ALUopSel = 0x016 / instr[6:2]
  - 00101 addi: ALUinB|Rwe = 0x024 / 00000
  - 00111 sw: ALUinB|DMwe = 0x028 / 00000
  - 01000 lw: ALUinB|Rwe|Rwd = 0x025 / 00000
  - 00001 j: JP = 0x040 / 00000
  - 00011 jal: JP|JAL|Rwe = 0x144 / 00000
  - 00100 jr: JR = 0x200 / 00000
  - 00010 bne: BR = 0x080 / 00001
  - 00110 blt: BR = 0x080 / 00001
  - 10101 setx: SETX|Rwe = 0x404 / 00000
  - 10110 bex: BEX = 0x800 / 00000
  - any other opcode: ctrl = 0, alu_op = 0, illegal = 1
- Decode is combinational; its result is registered into stage 0. Latency instr -> stage 0 is 1 cycle; stage k is available k+1 cycles after the instruction is presented.
- Normal advance (no stall, no flush):
  - stage0 <= {decode, in_valid}
  - stage k <= stage k-1 for k = 1..DEPTH-1
- stall=1, flush=0: stage 0 holds (word, valid, id_illegal). Stage 1 <= bubble (word 0, valid 0). Stages 2.. advance.
- flush=1 (regardless of stall): stages 0 and 1 <= bubble, id_illegal <= 0. Stages 2.. advance. Flush wins over stall.
- in_valid=0: stage 0 loads a bubble (word forced to 0, valid 0, id_illegal 0).
- illegal_cnt increments by 1 on an edge where in_valid & illegal & !stall & !flush & !reset. It saturates at 2^CNT_W-1 and never wraps.
- The last stage simply drops its contents on advance; no backpressure exists beyond stall.

Decomposition:
- Shared header/package ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, ... OP_BEX)
  - ctrl bit index constants (CB_RWD .. CB_BEX)
  - CTRL_W = 12, ALUOP_W = 5, WORD_W = 17
  - ALU_ADD = 5'b00000, ALU_SUB = 5'b00001
- One natural sub-module: ctrl_opcode_decode, purely combinational. Inputs instr[31:0]; outputs ctrl[11:0], alu_op[4:0], illegal. It is reused by a future multi-issue variant.
- The stage-register array lives in ctrl_pipe_decoder using a generate loop.

Test Plan:
- Reset, then lw instr=0x40000000 with in_valid=1 for 1 cycle -> next cycle stage_word[0] = {00000, 0x025}, stage_valid = 0001. Three cycles later stage 3 holds the same word and stage_valid = 1000.
- R-type sub instr=0x00000004, then bne instr=0x10000000 -> stage 0 = {00001, 0x016}, then {00001, 0x080}. addi 0x28000000 -> 0x024; sw 0x38000000 -> 0x028; jal 0x18000000 -> 0x144.
- Stream lw, add, add with stall=1 for one cycle after lw reaches stage 0 -> stage 0 holds the first add for 2 cycles. Stage 1 shows valid=0 and word 0 for one cycle; lw continues into stage 2 on schedule.
- stall=1 and flush=1 in the same cycle with valid stages 0..3 -> stages 0 and 1 invalid with zero words, stages 2 and 3 hold the former stages 1 and 2.
- Opcode 11111 (instr=0xF8000000) with in_valid=1 -> id_illegal=1 and ctrl=0. illegal_cnt goes to 1, but is not incremented on a stalled repeat or when flush is asserted. With CNT_W=2, five illegal instructions leave the count at 3.
- Reset asserted while 4 valid stages are in flight -> next edge: stage_valid=0, all words 0, illegal_cnt=0. The first instruction after reset deasserts appears in stage 0 one cycle later.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the pipelined control decoder.
// Opcodes, control-word bit positions and field widths.
package ctrl_pkg;

    localparam int CTRL_W  = 12;
    localparam int ALUOP_W = 5;
    localparam int WORD_W  = CTRL_W + ALUOP_W;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam int CB_RWD      = 0;
    localparam int CB_RDST     = 1;
    localparam int CB_RWE      = 2;
    localparam int CB_DMWE     = 3;
    localparam int CB_ALUOPSEL = 4;
    localparam int CB_ALUINB   = 5;
    localparam int CB_JP       = 6;
    localparam int CB_BR       = 7;
    localparam int CB_JAL      = 8;
    localparam int CB_JR       = 9;
    localparam int CB_SETX     = 10;
    localparam int CB_BEX      = 11;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 5'b00000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 5'b00001;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode decoder: instruction to control word and ALU op.
// Shared with the planned multi-issue front end.
module ctrl_opcode_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]        instr,
    output logic [CTRL_W-1:0]  ctrl,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal
);

    logic [4:0] op;
    logic       unused_bits;

    assign op          = instr[31:27];
    assign unused_bits = ^{instr[26:7], instr[1:0]};

    always_comb begin
        ctrl    = '0;
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                ctrl[CB_RWE]      = 1'b1;
                ctrl[CB_RDST]     = 1'b1;
                ctrl[CB_ALUOPSEL] = 1'b1;
                alu_op            = instr[6:2];
            end
            OP_ADDI: begin
                ctrl[CB_ALUINB] = 1'b1;
                ctrl[CB_RWE]    = 1'b1;
            end
            OP_SW: begin
                ctrl[CB_ALUINB] = 1'b1;
                ctrl[CB_DMWE]   = 1'b1;
            end
            OP_LW: begin
                ctrl[CB_ALUINB] = 1'b1;
                ctrl[CB_RWE]    = 1'b1;
                ctrl[CB_RWD]    = 1'b1;
            end
            OP_J: ctrl[CB_JP] = 1'b1;
            OP_JAL: begin
                ctrl[CB_JP]  = 1'b1;
                ctrl[CB_JAL] = 1'b1;
                ctrl[CB_RWE] = 1'b1;
            end
            OP_JR: ctrl[CB_JR] = 1'b1;
            OP_BNE, OP_BLT: begin
                // Branches compare by subtraction in the ALU
                ctrl[CB_BR] = 1'b1;
                alu_op      = ALU_SUB;
            end
            OP_SETX: begin
                ctrl[CB_SETX] = 1'b1;
                ctrl[CB_RWE]  = 1'b1;
            end
            OP_BEX: ctrl[CB_BEX] = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_decoder.sv
// Decodes fetched instructions and carries the control word down a
// DEPTH-stage valid-tagged pipeline with stall bubbles and flush.
module ctrl_pipe_decoder
    import ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [31:0]             instr,
    input  logic                    stall,
    input  logic                    flush,
    output logic [DEPTH*WORD_W-1:0] stage_word,
    output logic [DEPTH-1:0]        stage_valid,
    output logic                    id_illegal,
    output logic [CNT_W-1:0]        illegal_cnt
);

    logic [CTRL_W-1:0]  dec_ctrl;
    logic [ALUOP_W-1:0] dec_alu;
    logic               dec_illegal;

    logic [WORD_W-1:0] word_q [DEPTH];
    logic [WORD_W-1:0] word_d [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic              ill_q;
    logic              ill_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    ctrl_opcode_decode u_dec (
        .instr   (instr),
        .ctrl    (dec_ctrl),
        .alu_op  (dec_alu),
        .illegal (dec_illegal)
    );

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ill_d   = ill_q;
        for (int k = 2; k < DEPTH; k++) begin
            word_d[k]  = word_q[k-1];
            valid_d[k] = valid_q[k-1];
        end
        if (flush) begin
            word_d[0]  = '0;
            valid_d[0] = 1'b0;
            ill_d      = 1'b0;
            word_d[1]  = '0;
            valid_d[1] = 1'b0;
        end else if (stall) begin
            word_d[1]  = '0;
            valid_d[1] = 1'b0;
        end else begin
            word_d[1]  = word_q[0];
            valid_d[1] = valid_q[0];
            word_d[0]  = in_valid ? {dec_alu, dec_ctrl} : '0;
            valid_d[0] = in_valid;
            ill_d      = in_valid & dec_illegal;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && dec_illegal && !stall && !flush && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        always_ff @(posedge clock) begin
            if (reset) begin
                word_q[k]  <= '0;
                valid_q[k] <= 1'b0;
            end else begin
                word_q[k]  <= word_d[k];
                valid_q[k] <= valid_d[k];
            end
        end
        assign stage_word[k*WORD_W +: WORD_W] = word_q[k];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ill_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            ill_q <= ill_d;
            cnt_q <= cnt_d;
        end
    end

    assign stage_valid = valid_q;
    assign id_illegal  = ill_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// Randomised bench for ctrl_pipe_decoder against a table-driven model.
// A second DEPTH=2 / CNT_W=2 instance exercises the counter ceiling.
module tb_ctrl_pipe_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic [67:0] stage_word;
    logic [3:0]  stage_valid;
    logic        id_illegal;
    logic [7:0]  illegal_cnt;

    logic [33:0] word2;
    logic [1:0]  valid2;
    logic        ill2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    logic [16:0] mw [4];
    logic [3:0]  mv;
    logic        mill;
    int          mcnt;
    int          mcnt2;

    logic [4:0] legal_ops [11] = '{5'b00000, 5'b00101, 5'b00111, 5'b01000,
                                   5'b00001, 5'b00011, 5'b00100, 5'b00010,
                                   5'b00110, 5'b10101, 5'b10110};

    ctrl_pipe_decoder #(.DEPTH(4), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .instr       (instr),
        .stall       (stall),
        .flush       (flush),
        .stage_word  (stage_word),
        .stage_valid (stage_valid),
        .id_illegal  (id_illegal),
        .illegal_cnt (illegal_cnt)
    );

    ctrl_pipe_decoder #(.DEPTH(2), .CNT_W(2)) dut2 (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .instr       (instr),
        .stall       (stall),
        .flush       (flush),
        .stage_word  (word2),
        .stage_valid (valid2),
        .id_illegal  (ill2),
        .illegal_cnt (cnt2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [67:0] got,
                       input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {illegal, alu_op, ctrl} straight from the decode table
    function automatic logic [17:0] ref_dec(input logic [31:0] ins);
        case (ins[31:27])
            5'b00000: return {1'b0, ins[6:2], 12'h016};
            5'b00101: return {1'b0, 5'd0, 12'h024};
            5'b00111: return {1'b0, 5'd0, 12'h028};
            5'b01000: return {1'b0, 5'd0, 12'h025};
            5'b00001: return {1'b0, 5'd0, 12'h040};
            5'b00011: return {1'b0, 5'd0, 12'h144};
            5'b00100: return {1'b0, 5'd0, 12'h200};
            5'b00010: return {1'b0, 5'd1, 12'h080};
            5'b00110: return {1'b0, 5'd1, 12'h080};
            5'b10101: return {1'b0, 5'd0, 12'h404};
            5'b10110: return {1'b0, 5'd0, 12'h800};
            default:  return {1'b1, 17'd0};
        endcase
    endfunction

    task automatic model_step();
        logic [17:0] d;
        if (reset) begin
            for (int k = 0; k < 4; k++) mw[k] = '0;
            mv    = '0;
            mill  = 1'b0;
            mcnt  = 0;
            mcnt2 = 0;
        end else begin
            mw[3] = mw[2];
            mv[3] = mv[2];
            mw[2] = mw[1];
            mv[2] = mv[1];
            if (stall || flush) begin
                mw[1] = '0;
                mv[1] = 1'b0;
            end else begin
                mw[1] = mw[0];
                mv[1] = mv[0];
            end
            if (flush) begin
                mw[0] = '0;
                mv[0] = 1'b0;
                mill  = 1'b0;
            end else if (!stall) begin
                d     = ref_dec(instr);
                mw[0] = in_valid ? d[16:0] : 17'd0;
                mv[0] = in_valid;
                mill  = in_valid && d[17];
                if (in_valid && d[17]) begin
                    if (mcnt < 255) mcnt++;
                    if (mcnt2 < 3) mcnt2++;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [67:0] p;
        p = {mw[3], mw[2], mw[1], mw[0]};
        chk("word", stage_word, p);
        chk("valid", stage_valid, 68'(mv));
        chk("illegal", id_illegal, 68'(mill));
        chk("cnt", illegal_cnt, 68'(mcnt));
        chk("word2", word2, 68'(p[33:0]));
        chk("valid2", valid2, 68'(mv[1:0]));
        chk("ill2", ill2, 68'(mill));
        chk("cnt2", cnt2, 68'(mcnt2));
    endtask

    task automatic drive(input logic v, input logic [31:0] i,
                         input logic s, input logic f, input logic r);
        in_valid = v;
        instr    = i;
        stall    = s;
        flush    = f;
        reset    = r;
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) == 0) return r;
        return {legal_ops[$urandom_range(0, 10)], r[26:0]};
    endfunction

    initial begin
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("rst_valid", stage_valid, 0);
        chk("rst_cnt", illegal_cnt, 0);

        drive(1, 32'h4000_0000, 0, 0, 0);
        chk("lw_s0", stage_word[16:0], {5'd0, 12'h025});
        chk("lw_v0", stage_valid, 4'b0001);
        repeat (3) drive(0, 0, 0, 0, 0);
        chk("lw_s3", stage_word[67:51], {5'd0, 12'h025});
        chk("lw_v3", stage_valid, 4'b1000);

        drive(1, 32'h0000_0004, 0, 0, 0);
        chk("sub", stage_word[16:0], {5'b00001, 12'h016});
        drive(1, 32'h1000_0000, 0, 0, 0);
        chk("bne", stage_word[16:0], {5'b00001, 12'h080});
        drive(1, 32'h2800_0000, 0, 0, 0);
        chk("addi", stage_word[16:0], {5'd0, 12'h024});
        drive(1, 32'h3800_0000, 0, 0, 0);
        chk("sw", stage_word[16:0], {5'd0, 12'h028});
        drive(1, 32'h1800_0000, 0, 0, 0);
        chk("jal", stage_word[16:0], {5'd0, 12'h144});

        drive(1, 32'h4000_0000, 0, 0, 0);
        drive(1, 32'h0000_0008, 0, 0, 0);
        drive(1, 32'h0000_000C, 1, 0, 0);
        chk("stl_s0", stage_word[16:0], {5'd2, 12'h016});
        chk("stl_v1", stage_valid[1], 0);
        chk("stl_w1", stage_word[33:17], 0);
        chk("stl_s2", stage_word[50:34], {5'd0, 12'h025});
        drive(1, 32'h0000_000C, 0, 0, 0);
        chk("stl2_s0", stage_word[16:0], {5'd3, 12'h016});
        chk("stl2_s1", stage_word[33:17], {5'd2, 12'h016});
        chk("stl2_s3", stage_word[67:51], {5'd0, 12'h025});

        drive(1, 32'h2800_0000, 0, 0, 0);
        drive(1, 32'h3800_0000, 0, 0, 0);
        drive(1, 32'h1800_0000, 0, 0, 0);
        drive(1, 32'h0800_0000, 0, 0, 0);
        drive(1, 32'hB000_0000, 1, 1, 0);
        chk("sf_valid", stage_valid, 4'b1100);
        chk("sf_low", stage_word[33:0], 0);
        chk("sf_s2", stage_word[50:34], {5'd0, 12'h144});
        chk("sf_s3", stage_word[67:51], {5'd0, 12'h028});

        drive(1, 32'hF800_0000, 0, 0, 0);
        chk("ill_flag", id_illegal, 1);
        chk("ill_word", stage_word[16:0], 0);
        chk("ill_cnt1", illegal_cnt, 1);
        drive(1, 32'hF800_0000, 1, 0, 0);
        chk("ill_stall", illegal_cnt, 1);
        drive(1, 32'hF800_0000, 0, 1, 0);
        chk("ill_flush", illegal_cnt, 1);
        chk("ill_fl_flag", id_illegal, 0);
        repeat (5) drive(1, 32'hF800_0000, 0, 0, 0);
        chk("sat2", cnt2, 2'd3);
        chk("cnt6", illegal_cnt, 6);

        repeat (4) drive(1, 32'h2800_0000, 0, 0, 0);
        drive(1, 32'h2800_0000, 0, 0, 1);
        chk("mrst_valid", stage_valid, 0);
        chk("mrst_word", stage_word, 0);
        chk("mrst_cnt", illegal_cnt, 0);
        drive(1, 32'h2800_0000, 0, 0, 0);
        chk("post_rst", stage_word[16:0], {5'd0, 12'h024});
        chk("post_rst_v", stage_valid, 4'b0001);

        repeat (3000) begin
            drive($urandom_range(0, 9) != 0, rand_instr(),
                  $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 59) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
